// File: rtl/traffic_pkg.sv
// Shared definitions for the signal phase controller: phase encoding, light codes,
// road indices and the green-clamp / next-road selection helpers.
package traffic_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } phase_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  localparam logic [1:0] ROAD_N = 2'd0;
  localparam logic [1:0] ROAD_E = 2'd1;
  localparam logic [1:0] ROAD_S = 2'd2;
  localparam logic [1:0] ROAD_W = 2'd3;

  function automatic logic [7:0] clamp_green(input logic [7:0] tg,
                                             input logic [7:0] lo,
                                             input logic [7:0] hi);
    logic [7:0] r;
    r = tg;
    if (tg < lo) r = lo;
    else if (tg > hi) r = hi;
    return r;
  endfunction

  // First road after cur (wrapping) with waiting vehicles; plain round robin if none.
  function automatic logic [1:0] pick_next(input logic [1:0]  cur,
                                           input logic [31:0] counts);
    logic [1:0] cand;
    logic [1:0] sel;
    logic       found;
    sel   = cur + 2'd1;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      cand = cur + 2'(k);
      if (!found && counts[{cand, 3'b000} +: 8] != 8'd0) begin
        sel   = cand;
        found = 1'b1;
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/signal_phase_controller_if.sv
// Bundle of the adaptation-unit inputs and the light/status outputs of the controller.
interface signal_phase_controller_if;
  logic       tick;
  logic [7:0] TGn, TGe, TGs, TGw;
  logic [7:0] N_n, N_e, N_s, N_w;
  logic [1:0] next_road;
  logic [1:0] cur_road;
  logic [2:0] light_n, light_e, light_s, light_w;
  logic [1:0] phase;
  logic [7:0] time_left;

  modport master (
    output tick, TGn, TGe, TGs, TGw, N_n, N_e, N_s, N_w,
    input  next_road, cur_road, light_n, light_e, light_s, light_w, phase, time_left
  );

  modport slave (
    input  tick, TGn, TGe, TGs, TGw, N_n, N_e, N_s, N_w,
    output next_road, cur_road, light_n, light_e, light_s, light_w, phase, time_left
  );
endinterface

// File: rtl/phase_timer.sv
// Loadable 8-bit down-counter advanced by tick; done marks the last tick of a phase.
module phase_timer #(
  parameter int RESET_VAL = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic       done
);

  assign done = tick && (count == 8'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= 8'(RESET_VAL);
    else if (load) count <= load_val;
    else if (tick && count != 8'd0) count <= count - 8'd1;
  end

endmodule

// File: rtl/signal_phase_controller.sv
// Four-road traffic phase controller: ALL_RED -> GREEN -> YELLOW cycle with
// clamped adaptive green time and demand-driven selection of the next road.
module signal_phase_controller
  import traffic_pkg::*;
#(
  parameter int MIN_GREEN   = 5,
  parameter int MAX_GREEN   = 60,
  parameter int YELLOW_TIME = 3,
  parameter int ALLRED_TIME = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  signal_phase_controller_if.slave  bus
);

  phase_t      state_q, state_d;
  logic [1:0]  cur_q, next_q;
  logic        done;
  logic [7:0]  time_left;
  logic [7:0]  load_val;
  logic [7:0]  tg_sel;
  logic [31:0] counts;
  logic [2:0]  light [4];

  assign counts = {bus.N_w, bus.N_s, bus.N_e, bus.N_n};

  always_comb begin
    case (next_q)
      ROAD_N:  tg_sel = bus.TGn;
      ROAD_E:  tg_sel = bus.TGe;
      ROAD_S:  tg_sel = bus.TGs;
      default: tg_sel = bus.TGw;
    endcase
  end

  // The timer reloads on the same edge that ends a phase.
  phase_timer #(.RESET_VAL(ALLRED_TIME)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .tick     (bus.tick),
    .load     (done),
    .load_val (load_val),
    .count    (time_left),
    .done     (done)
  );

  always_comb begin
    state_d  = state_q;
    load_val = 8'(ALLRED_TIME);
    case (state_q)
      ST_ALL_RED: begin
        load_val = clamp_green(tg_sel, 8'(MIN_GREEN), 8'(MAX_GREEN));
        if (done) state_d = ST_GREEN;
      end
      ST_GREEN: begin
        load_val = 8'(YELLOW_TIME);
        if (done) state_d = ST_YELLOW;
      end
      ST_YELLOW: begin
        load_val = 8'(ALLRED_TIME);
        if (done) state_d = ST_ALL_RED;
      end
      default: state_d = ST_ALL_RED;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_ALL_RED;
      cur_q   <= ROAD_N;
      next_q  <= ROAD_N;
    end else begin
      state_q <= state_d;
      if (done && state_q == ST_ALL_RED) cur_q  <= next_q;
      if (done && state_q == ST_GREEN)   next_q <= pick_next(cur_q, counts);
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      light[i] = RED;
      if (cur_q == 2'(i)) begin
        if (state_q == ST_GREEN)       light[i] = GREEN;
        else if (state_q == ST_YELLOW) light[i] = YELLOW;
      end
    end
  end

  assign bus.light_n   = light[ROAD_N];
  assign bus.light_e   = light[ROAD_E];
  assign bus.light_s   = light[ROAD_S];
  assign bus.light_w   = light[ROAD_W];
  assign bus.phase     = state_q;
  assign bus.cur_road  = cur_q;
  assign bus.next_road = next_q;
  assign bus.time_left = time_left;

endmodule

// File: tb/tb_signal_phase_controller.sv
// Bench for signal_phase_controller: directed scenarios plus randomized traffic,
// compared each cycle against a phase-schedule reference model.
module tb_signal_phase_controller;
  import traffic_pkg::*;

  logic clk = 1'b0;
  logic reset;
  signal_phase_controller_if bus();

  signal_phase_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the segment currently shown and what follows it.
  phase_t m_kind;
  int     m_road, m_next, m_left;
  int     tg [4];
  int     cnt[4];

  function automatic int clampi(input int v);
    return (v < 5) ? 5 : ((v > 60) ? 60 : v);
  endfunction

  function automatic int choose(input int cur);
    for (int k = 1; k <= 3; k++)
      if (cnt[(cur + k) % 4] != 0) return (cur + k) % 4;
    return (cur + 1) % 4;
  endfunction

  function automatic logic [2:0] exp_light(input int road);
    if (road != m_road || m_kind == ST_ALL_RED) return RED;
    return (m_kind == ST_GREEN) ? GREEN : YELLOW;
  endfunction

  task automatic model_reset();
    m_kind = ST_ALL_RED; m_left = 1; m_road = 0; m_next = 0;
  endtask

  task automatic model_tick();
    if (m_left > 1) m_left = m_left - 1;
    else if (m_kind == ST_ALL_RED) begin
      m_kind = ST_GREEN; m_road = m_next; m_left = clampi(tg[m_next]);
    end else if (m_kind == ST_GREEN) begin
      m_kind = ST_YELLOW; m_left = 3; m_next = choose(m_road);
    end else begin
      m_kind = ST_ALL_RED; m_left = 1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int nonred;
    chk("phase",     32'(bus.phase),     32'(m_kind));
    chk("time_left", 32'(bus.time_left), 32'(m_left));
    chk("cur_road",  32'(bus.cur_road),  32'(m_road));
    chk("next_road", 32'(bus.next_road), 32'(m_next));
    chk("light_n",   32'(bus.light_n),   32'(exp_light(0)));
    chk("light_e",   32'(bus.light_e),   32'(exp_light(1)));
    chk("light_s",   32'(bus.light_s),   32'(exp_light(2)));
    chk("light_w",   32'(bus.light_w),   32'(exp_light(3)));
    nonred = int'(bus.light_n != RED) + int'(bus.light_e != RED)
           + int'(bus.light_s != RED) + int'(bus.light_w != RED);
    chk("one_nonred", 32'(nonred <= 1), 32'd1);
  endtask

  task automatic drive();
    bus.TGn = 8'(tg[0]); bus.TGe = 8'(tg[1]); bus.TGs = 8'(tg[2]); bus.TGw = 8'(tg[3]);
    bus.N_n = 8'(cnt[0]); bus.N_e = 8'(cnt[1]); bus.N_s = 8'(cnt[2]); bus.N_w = 8'(cnt[3]);
  endtask

  task automatic step(input logic t);
    @(negedge clk);
    bus.tick = t;
    drive();
    @(posedge clk);
    if (t && !reset) model_tick();
    #1 check_all();
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    @(negedge clk);
    reset = 1'b0;
    bus.tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    step(1'b1);
    step(1'b1);
    @(negedge clk);
    reset = 1'b0;
    bus.tick = 1'b0;
  endtask

  initial begin
    int held;
    int exp_next, n_trans;
    phase_t prev;
    reset = 1'b1;
    bus.tick = 1'b0;
    for (int i = 0; i < 4; i++) begin tg[i] = 10; cnt[i] = 5; end
    drive();
    model_reset();

    // Basic cycle with clamping: N 10 ticks, E clamped up to 5, S clamped down to 60.
    tg[0] = 10; tg[1] = 2; tg[2] = 200; tg[3] = 10;
    do_reset();
    step(1'b1);
    chk("n_green_phase", 32'(bus.phase), 32'(ST_GREEN));
    chk("n_green_time",  32'(bus.time_left), 32'd10);
    chk("n_green_light", 32'(bus.light_n), 32'(GREEN));
    for (int i = 0; i < 10; i++) step(1'b1);
    chk("n_yellow_phase", 32'(bus.phase), 32'(ST_YELLOW));
    chk("n_yellow_time",  32'(bus.time_left), 32'd3);
    chk("n_yellow_next",  32'(bus.next_road), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("allred_phase", 32'(bus.phase), 32'(ST_ALL_RED));
    chk("allred_time",  32'(bus.time_left), 32'd1);
    step(1'b1);
    chk("e_green_cur",  32'(bus.cur_road), 32'd1);
    chk("e_green_time", 32'(bus.time_left), 32'd5);
    for (int i = 0; i < 9; i++) step(1'b1);
    chk("s_green_cur",  32'(bus.cur_road), 32'd2);
    chk("s_green_time", 32'(bus.time_left), 32'd60);

    // Tick withheld mid-green: everything holds, TG changes ignored.
    for (int i = 0; i < 10; i++) step(1'b1);
    held = int'(bus.time_left);
    tg[2] = 7;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("hold_time",  32'(bus.time_left), 32'(held));
    chk("hold_phase", 32'(bus.phase), 32'(ST_GREEN));
    chk("hold_light", 32'(bus.light_s), 32'(GREEN));
    for (int i = 0; i < 50; i++) step(1'b1);
    chk("s_green_end", 32'(bus.phase), 32'(ST_YELLOW));

    // Demand skip: E empty, S waiting.
    tg[2] = 200;
    cnt[0] = 5; cnt[1] = 0; cnt[2] = 7; cnt[3] = 5;
    do_reset();
    for (int i = 0; i < 11; i++) step(1'b1);
    chk("skip_next", 32'(bus.next_road), 32'd2);
    for (int i = 0; i < 4; i++) step(1'b1);
    chk("skip_green_cur", 32'(bus.cur_road), 32'd2);
    chk("skip_green_phase", 32'(bus.phase), 32'(ST_GREEN));

    // No demand anywhere: strict round robin.
    for (int i = 0; i < 4; i++) begin tg[i] = 5; cnt[i] = 0; end
    do_reset();
    exp_next = 0; n_trans = 0; prev = ST_ALL_RED;
    for (int i = 0; i < 60; i++) begin
      step(1'b1);
      if (bus.phase == ST_YELLOW && prev == ST_GREEN) begin
        exp_next = (exp_next + 1) % 4;
        n_trans++;
        chk("rr_next", 32'(bus.next_road), 32'(exp_next));
      end
      prev = phase_t'(bus.phase);
    end
    chk("rr_count", 32'(n_trans >= 5), 32'd1);

    // Reset mid-green abandons the phase; N comes back first.
    for (int i = 0; i < 4; i++) begin tg[i] = 10; cnt[i] = 5; end
    do_reset();
    for (int i = 0; i < 7; i++) step(1'b1);
    chk("pre_rst_time", 32'(bus.time_left), 32'd4);
    pulse_reset();
    chk("rst_light_n", 32'(bus.light_n), 32'(RED));
    chk("rst_time",    32'(bus.time_left), 32'd1);
    chk("rst_next",    32'(bus.next_road), 32'd0);
    step(1'b1);
    chk("post_rst_phase", 32'(bus.phase), 32'(ST_GREEN));
    chk("post_rst_cur",   32'(bus.cur_road), 32'd0);

    // Randomized traffic, tick gaps and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int i = 0; i < 4; i++) begin
          tg[i]  = int'($urandom_range(0, 255));
          cnt[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 255));
        end
      end
      step($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
